// File: rtl/CDB_types.sv
// Shared rename/ROB constants and types: physical-register index and free-list pointer.
package CDB_types;

   localparam int unsigned P_REG_NUM = 64;
   localparam int unsigned FL_DEPTH  = P_REG_NUM - 32;

   typedef logic [$clog2(FL_DEPTH):0]   fl_ptr_t;
   typedef logic [$clog2(P_REG_NUM)-1:0] preg_t;

   // Reset contents of slot i: architectural regs p0..p31 are mapped, the rest are free.
   function automatic preg_t reset_pd(input int unsigned i);
      return preg_t'(P_REG_NUM - FL_DEPTH + i);
   endfunction

endpackage

// File: rtl/free_list.sv
// Circular free list of physical-register indices with checkpointed head for flush recovery.
// Optional combinational enq->pd bypass on an empty list when FREE_LIST_BYPASS_EN is defined.
module free_list #(
   parameter int unsigned P_REG_NUM = CDB_types::P_REG_NUM,
   parameter int unsigned FL_DEPTH  = CDB_types::FL_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         deq,
   output logic [$clog2(P_REG_NUM)-1:0] free_list_pd,
   output logic                         empty,
   input  logic                         enq,
   input  logic [$clog2(P_REG_NUM)-1:0] enq_pd,
   output logic                         full,
   output logic [$clog2(FL_DEPTH):0]    free_list_head,
   input  logic                         flush,
   input  logic [$clog2(FL_DEPTH):0]    flush_head,
   output logic [$clog2(FL_DEPTH):0]    count
);

   localparam int unsigned PW = $clog2(P_REG_NUM);
   localparam int unsigned IW = $clog2(FL_DEPTH);
   localparam logic [IW:0] DEPTH_PTR = (IW+1)'(FL_DEPTH);

   logic [PW-1:0] mem_q [FL_DEPTH];
   logic [IW:0]   head_q, head_d;
   logic [IW:0]   tail_q, tail_d;
   logic          empty_raw;
   logic          enq_ok;
   logic          do_deq;
   logic          do_write;
   logic          bypass_hit;

   assign empty_raw = (head_q == tail_q);
   assign full      = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
   assign enq_ok    = enq && (enq_pd != '0) && !full;

`ifdef FREE_LIST_BYPASS_EN
   assign bypass_hit = empty_raw && enq && (enq_pd != '0);
`else
   assign bypass_hit = 1'b0;
`endif

   always_comb begin
      free_list_pd   = bypass_hit ? enq_pd : mem_q[head_q[IW-1:0]];
      empty          = empty_raw && !bypass_hit;
      free_list_head = head_q;
      count          = tail_q - head_q;
   end

   assign do_deq = deq && !empty && !flush;
   // A bypassed entry consumed in the same cycle never needs to land in storage.
   assign do_write = enq_ok && !(bypass_hit && do_deq);

   always_comb begin
      head_d = head_q;
      if (flush) begin
         head_d = flush_head;
      end else if (do_deq) begin
         head_d = head_q + 1'b1;
      end
   end

   always_comb begin
      tail_d = tail_q;
      if (enq_ok) begin
         tail_d = tail_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= DEPTH_PTR;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(FL_DEPTH); i++) begin
            mem_q[i] <= PW'(P_REG_NUM - FL_DEPTH + i);
         end
      end else if (do_write) begin
         mem_q[tail_q[IW-1:0]] <= enq_pd;
      end
   end

   // Protocol checks: no return into a full list, and a restored head never overfills it.
   enq_not_full_a : assert property (@(posedge clk) disable iff (rst)
      !(enq && (enq_pd != '0) && full));

   flush_occupancy_a : assert property (@(posedge clk) disable iff (rst)
      flush |-> (IW+1)'(tail_d - flush_head) <= DEPTH_PTR);

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for free_list; build with FREE_LIST_BYPASS_EN to cover the bypass.
module tb_free_list;

   logic       clk;
   logic       rst;
   logic       deq;
   logic [5:0] free_list_pd;
   logic       empty;
   logic       enq;
   logic [5:0] enq_pd;
   logic       full;
   logic [5:0] free_list_head;
   logic       flush;
   logic [5:0] flush_head;
   logic [5:0] count;

   int total = 0;
   int bad   = 0;

   free_list #(
      .P_REG_NUM(64),
      .FL_DEPTH (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .deq           (deq),
      .free_list_pd  (free_list_pd),
      .empty         (empty),
      .enq           (enq),
      .enq_pd        (enq_pd),
      .full          (full),
      .free_list_head(free_list_head),
      .flush         (flush),
      .flush_head    (flush_head),
      .count         (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      deq        = 1'b0;
      enq        = 1'b0;
      enq_pd     = '0;
      flush      = 1'b0;
      flush_head = '0;
   endtask

   initial begin
      int q[$];
      int exp_drain[11];
      int exp_ck[4];
      bit do_e;
      bit do_d;
      int v;

      exp_drain = '{41, 42, 43, 44, 45, 46, 47, 48, 49, 9, 12};
      exp_ck    = '{41, 42, 43, 44};

      idle();
      rst = 1'b1;
      #22;
      rst = 1'b0;
      step();

      chk("rst_pd", free_list_pd, 32);
      chk("rst_full", full, 1);
      chk("rst_empty", empty, 0);
      chk("rst_count", count, 32);
      chk("rst_head", free_list_head, 0);

      // Drain the reset image: 32..63 in order.
      deq = 1'b1;
      for (int i = 0; i < 32; i++) begin
         chk("drain_pd", free_list_pd, 32 + i);
         step();
      end
      deq = 1'b0;
      chk("drained_empty", empty, 1);
      chk("drained_count", count, 0);
      chk("drained_head", free_list_head, 32);
      chk("drained_full", full, 0);

      deq = 1'b1;
      step();
      deq = 1'b0;
      chk("deq_empty_ignored", free_list_head, 32);

      enq    = 1'b1;
      enq_pd = 6'd5;
`ifndef FREE_LIST_BYPASS_EN
      #1;
      chk("no_bypass_empty", empty, 1);
`endif
      step();
      enq_pd = 6'd7;
      step();
      enq_pd = 6'd0;
      step();
      enq = 1'b0;
      chk("enq_p0_dropped", count, 2);

      deq = 1'b1;
      chk("ret_p5", free_list_pd, 5);
      step();
      chk("ret_p7", free_list_pd, 7);
      step();
      deq = 1'b0;
      chk("ret_empty", empty, 1);

      // Build occupancy 10 with 40..49.
      enq = 1'b1;
      for (int i = 0; i < 10; i++) begin
         enq_pd = 6'(40 + i);
         step();
      end
      enq = 1'b0;
      chk("fill10_count", count, 10);

      enq    = 1'b1;
      enq_pd = 6'd9;
      deq    = 1'b1;
      chk("simul_pd", free_list_pd, 40);
      step();
      idle();
      chk("simul_count", count, 10);
      chk("simul_head", free_list_head, 35);

      // Checkpoint at head 35, consume 4, then restore with a concurrent commit of p12.
      deq = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("ck_pd", free_list_pd, exp_ck[i]);
         step();
      end
      deq = 1'b0;
      chk("ck_head", free_list_head, 39);
      chk("ck_count", count, 6);

      flush      = 1'b1;
      flush_head = 6'd35;
      deq        = 1'b1;
      enq        = 1'b1;
      enq_pd     = 6'd12;
      step();
      idle();
      chk("flush_head", free_list_head, 35);
      chk("flush_count", count, 11);

      deq = 1'b1;
      for (int i = 0; i < 11; i++) begin
         chk("reissue_pd", free_list_pd, exp_drain[i]);
         step();
      end
      deq = 1'b0;
      chk("reissue_empty", empty, 1);

      // Random traffic across the pointer wrap, against a reference queue.
      for (int c = 0; c < 100; c++) begin
         do_e   = (q.size() < 32) && ($urandom_range(0, 99) < 60);
         do_d   = (q.size() > 0) && ($urandom_range(0, 99) < 50);
         v      = $urandom_range(1, 63);
         enq    = do_e;
         enq_pd = 6'(v);
         deq    = do_d;
         chk("rand_count", count, q.size());
         if (do_d) chk("rand_pd", free_list_pd, q[0]);
         step();
         if (do_d) void'(q.pop_front());
         if (do_e) q.push_back(v);
      end
      idle();

      enq = 1'b1;
      while (q.size() < 32) begin
         v      = $urandom_range(1, 63);
         enq_pd = 6'(v);
         step();
         q.push_back(v);
      end
      enq = 1'b0;
      chk("refill_full", full, 1);
      chk("refill_count", count, 32);

      deq = 1'b1;
      while (q.size() > 0) begin
         chk("final_pd", free_list_pd, q[0]);
         step();
         void'(q.pop_front());
      end
      deq = 1'b0;
      chk("final_empty", empty, 1);

`ifdef FREE_LIST_BYPASS_EN
      enq    = 1'b1;
      enq_pd = 6'd20;
      deq    = 1'b1;
      #1;
      chk("bypass_pd", free_list_pd, 20);
      chk("bypass_empty", empty, 0);
      step();
      idle();
      chk("bypass_after_empty", empty, 1);
      chk("bypass_after_count", count, 0);
`endif

      // Asynchronous reset mid-operation.
      enq    = 1'b1;
      enq_pd = 6'd33;
      step();
      idle();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_count", count, 32);
      chk("arst_pd", free_list_pd, 32);
      chk("arst_head", free_list_head, 0);
      #2;
      rst = 1'b0;
      step();
      chk("arst_full", full, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
